// File: rtl/mux_cfg_pkg.sv
// Shared types and defaults for the routing-mux configuration controller.
// Optional feature macro used by the controller: MUX_CFG_PARITY_EN.
package mux_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } cfg_state_e;

    localparam int DEF_NUM_MUX = 8;
    localparam int DEF_SEL_W   = 5;
    localparam int DEF_TIMEOUT = 255;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_cfg_shadow_bank.sv
// Shadow select registers written one word per beat, read back packed.
// Contents only reach the muxes when the controller commits them.
module mux_cfg_shadow_bank
    import mux_cfg_pkg::*;
#(
    parameter int NUM_MUX = DEF_NUM_MUX,
    parameter int SEL_W   = DEF_SEL_W,
    localparam int PTR_W  = ptr_width(NUM_MUX)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [PTR_W-1:0]         ptr_i,
    input  logic [SEL_W-1:0]         wdata_i,
    output logic [NUM_MUX*SEL_W-1:0] shadow_o
);

    logic [SEL_W-1:0] shadow_q [NUM_MUX];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_MUX; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (we_i) begin
            shadow_q[ptr_i] <= wdata_i;
        end
    end

    always_comb begin
        shadow_o = '0;
        for (int k = 0; k < NUM_MUX; k++) begin
            shadow_o[k*SEL_W +: SEL_W] = shadow_q[k];
        end
    end

endmodule

// File: rtl/mux_cfg_ctrl.sv
// Streams select words into shadow regs and commits them atomically to sram/sram_inv.
// Define MUX_CFG_PARITY_EN to add the cfg_par port and per-beat even-parity check.
module mux_cfg_ctrl
    import mux_cfg_pkg::*;
#(
    parameter int NUM_MUX = DEF_NUM_MUX,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     prog_clk,
    input  logic                     rst_n,
    input  logic                     cfg_start,
    input  logic                     cfg_abort,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [SEL_W-1:0]         cfg_data,
`ifdef MUX_CFG_PARITY_EN
    input  logic                     cfg_par,
`endif
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic                     cfg_busy,
    output logic [NUM_MUX*SEL_W-1:0] sram,
    output logic [NUM_MUX*SEL_W-1:0] sram_inv
);

    localparam int PTR_W = ptr_width(NUM_MUX);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int BUS_W = NUM_MUX * SEL_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_MUX - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    cfg_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [BUS_W-1:0] sram_q, sram_d;
    logic [BUS_W-1:0] sram_inv_q, sram_inv_d;
    logic [BUS_W-1:0] shadow;
    logic             shadow_we;
    logic             accept;
    logic             par_bad;

`ifdef MUX_CFG_PARITY_EN
    assign par_bad = ^{cfg_data, cfg_par};
`else
    assign par_bad = 1'b0;
`endif

    assign cfg_ready = (state_q == LOAD);
    assign accept    = cfg_valid && cfg_ready;

    mux_cfg_shadow_bank #(
        .NUM_MUX (NUM_MUX),
        .SEL_W   (SEL_W)
    ) u_shadow (
        .clk_i    (prog_clk),
        .rst_ni   (rst_n),
        .we_i     (shadow_we),
        .ptr_i    (ptr_q),
        .wdata_i  (cfg_data),
        .shadow_o (shadow)
    );

    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            tmr_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            sram_q     <= '0;
            sram_inv_q <= '1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tmr_q      <= tmr_d;
            err_q      <= err_d;
            done_q     <= done_d;
            sram_q     <= sram_d;
            sram_inv_q <= sram_inv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tmr_d      = tmr_q;
        err_d      = err_q;
        done_d     = 1'b0;
        sram_d     = sram_q;
        sram_inv_d = sram_inv_q;
        shadow_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    tmr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                // Abort wins over a same-cycle beat and is not an error.
                if (cfg_abort) begin
                    state_d = IDLE;
                end else if (accept && par_bad) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    shadow_we = 1'b1;
                    tmr_d     = '0;
                    if (ptr_q == LAST_PTR) begin
                        state_d = COMMIT;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end else if (tmr_q == TMR_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            COMMIT: begin
                sram_d     = shadow;
                sram_inv_d = ~shadow;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign cfg_busy = (state_q == LOAD) || (state_q == COMMIT);
    assign sram     = sram_q;
    assign sram_inv = sram_inv_q;

endmodule

// File: tb/tb_mux_cfg_ctrl.sv
// Scoreboard bench for mux_cfg_ctrl: loads queue expected commits,
// a negedge monitor checks every commit and that sram holds otherwise.
module tb_mux_cfg_ctrl;

    localparam int NM = 8;
    localparam int SW = 5;
    localparam int W  = NM * SW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_par   = 1'b0;
    logic [SW-1:0] cfg_data  = '0;
    logic          cfg_ready;
    logic          cfg_done;
    logic          cfg_err;
    logic          cfg_busy;
    logic [W-1:0]  sram;
    logic [W-1:0]  sram_inv;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] active_m = '0;
    logic [SW-1:0] beat_d [NM];

    mux_cfg_ctrl dut (
        .prog_clk  (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
`ifdef MUX_CFG_PARITY_EN
        .cfg_par   (cfg_par),
`endif
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cfg_busy  (cfg_busy),
        .sram      (sram),
        .sram_inv  (sram_inv)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            active_m = '0;
            check("rst_sram", sram, '0);
            check("rst_inv", sram_inv, '1);
        end else if (cfg_done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want 0 sram=%h", sram);
            end else begin
                active_m = exp_q.pop_front();
                check("commit_sram", sram, active_m);
                check("commit_inv", sram_inv, ~active_m);
            end
        end else begin
            check("hold_sram", sram, active_m);
            check("hold_inv", sram_inv, ~active_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [SW-1:0] d, input int gap);
        repeat (gap) tick();
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_par   = ^d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("start_busy", cfg_busy, 1);
        check("start_ready", cfg_ready, 1);
        check("start_err_clr", cfg_err, 0);
    endtask

    task automatic do_load(input int gap, input logic ab_commit);
        logic [W-1:0] e;
        e = '0;
        for (int k = 0; k < NM; k++) e[k*SW +: SW] = beat_d[k];
        start();
        exp_q.push_back(e);
        for (int k = 0; k < NM; k++) beat(beat_d[k], gap);
        check("commit_ready", cfg_ready, 0);
        check("commit_busy", cfg_busy, 1);
        check("done_early", cfg_done, 0);
        cfg_abort = ab_commit;
        tick();
        cfg_abort = 1'b0;
        check("done_pulse", cfg_done, 1);
        check("done_sram", sram, e);
        tick();
        check("done_drop", cfg_done, 0);
        check("idle_busy", cfg_busy, 0);
        check("load_no_err", cfg_err, 0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        check("rst_ready", cfg_ready, 0);
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_busy", cfg_busy, 0);
        rst_n = 1'b1;
        tick();

        cfg_valid = 1'b1;
        cfg_data  = 5'h07;
        tick();
        tick();
        cfg_valid = 1'b0;
        check("idle_ready", cfg_ready, 0);
        check("idle_beats_ignored", cfg_busy, 0);

        for (int k = 0; k < NM; k++) beat_d[k] = SW'(k + 1);
        do_load(0, 1'b0);

        start();
        beat(5'h1F, 0);
        beat(5'h1E, 0);
        beat(5'h1D, 0);
        repeat (250) tick();
        check("tmo_still_load", cfg_busy, 1);
        check("tmo_no_err_yet", cfg_err, 0);
        n = 0;
        while (cfg_busy && n < 20) begin
            tick();
            n++;
        end
        check("tmo_exit", cfg_busy, 0);
        check("tmo_err", cfg_err, 1);
        check("tmo_ready", cfg_ready, 0);
        repeat (3) tick();
        check("tmo_err_sticky", cfg_err, 1);

        for (int k = 0; k < NM; k++) beat_d[k] = SW'(31 - k);
        do_load(10, 1'b0);

        start();
        for (int k = 0; k < 4; k++) beat(SW'(10 + k), 0);
        cfg_valid = 1'b1;
        cfg_data  = 5'h0E;
        cfg_par   = ^cfg_data;
        cfg_abort = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        check("abort_idle", cfg_busy, 0);
        check("abort_no_err", cfg_err, 0);
        check("abort_ready", cfg_ready, 0);
        repeat (3) tick();
        for (int k = 0; k < NM; k++) beat_d[k] = SW'(k + 1);
        do_load(0, 1'b0);

        for (int k = 0; k < NM; k++) beat_d[k] = SW'(3 * k);
        do_load(0, 1'b1);

`ifdef MUX_CFG_PARITY_EN
        start();
        cfg_valid = 1'b1;
        cfg_data  = 5'h03;
        cfg_par   = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("par_bad_idle", cfg_busy, 0);
        check("par_bad_err", cfg_err, 1);
        start();
        beat(5'h03, 0);
        check("par_ok_busy", cfg_busy, 1);
        check("par_ok_err", cfg_err, 0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("par_abort_idle", cfg_busy, 0);
`endif

        start();
        beat(5'h11, 0);
        beat(5'h12, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_sram", sram, '0);
        check("midrst_inv", sram_inv, '1);
        check("midrst_ready", cfg_ready, 0);
        check("midrst_busy", cfg_busy, 0);
        check("midrst_done", cfg_done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", cfg_busy, 0);
        check("post_rst_err", cfg_err, 0);
        tick();
        check("queue_empty", W'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
